top_uart: RTL and testbench
===========================

# top_uart

Parameterised UART transmitter top level: accepts a parallel byte with a one-cycle valid strobe and serialises it onto a single line as start bit, data LSB first, optional parity bit, and stop bit. It runs one bit per clock: the clock is the baud-rate clock supplied by the system clock/divider logic. Internally it consists of an FSM, a shift serializer, a parity calculator and an output mux. It sits between the register/data-sync domain and the physical TX pin of the UART block.

## Interface
- DATA_WIDTH, 8: width of parallel data word.
- CLK  input  1  baud-rate clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel data to transmit.
- DATA_VALID  input  1  request to transmit P_DATA; accepted only when idle.
- PAR_EN  input  1  1 = insert parity bit after data.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- TX_OUT  output  1  serial line; idles high.
- BUSY  output  1  high while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. If DATA_VALID=1 at a rising edge, the block latches P_DATA, PAR_EN and PAR_TYP into internal registers and moves to START.
- START: TX_OUT=0, BUSY=1. Moves to DATA next cycle.
- DATA: emits latched bit 0 first, through bit DATA_WIDTH-1, one bit per cycle. A bit counter is 0..DATA_WIDTH-1. After the last bit it moves to PARITY if the latched PAR_EN=1, else to STOP.
- PARITY: TX_OUT = XOR of latched data bits when PAR_TYP=0 (even), or its inverse when PAR_TYP=1 (odd). Parity is computed from the latched word, not from live P_DATA.
- STOP: TX_OUT=1, BUSY=1, then returns to IDLE.
- DATA_VALID is ignored in every state except IDLE. Changes to P_DATA, PAR_EN or PAR_TYP during a frame have no effect.
- If DATA_VALID is held high continuously, frames are sent back-to-back with exactly one IDLE cycle (TX_OUT=1, BUSY=0) between the STOP of one frame and the START of the next.

## Timing
- TX_OUT and BUSY are registered outputs, updated on the same edge as the state register.
- Edge k accepts DATA_VALID. After edge k: start bit. After edge k+1..k+DATA_WIDTH: data bits. Then the parity bit (if enabled), then the stop bit.
- Frame length with BUSY=1: DATA_WIDTH+3 cycles with parity (11 for 8-bit), DATA_WIDTH+2 without (10).
- BUSY falls on the edge following the stop-bit cycle.
- Reset values (RST=1 at any edge, including mid-frame): state IDLE, TX_OUT=1, BUSY=0, bit counter 0, data register 0. Reset takes priority over DATA_VALID.
- No combinational path from any input to TX_OUT or BUSY.

## Configuration
- Macro UART_PARITY_EN.
- Defined: parity logic and the PARITY state are compiled in, and behaviour is as above.
- Undefined: the parity calculator and PARITY state are omitted. PAR_EN and PAR_TYP remain as ports but are ignored. Every frame is start + data + stop (DATA_WIDTH+2 cycles).

## Test plan
- Reset: hold RST=1 for 2 cycles with DATA_VALID=1 -> TX_OUT=1, BUSY=0 throughout; after release, the first frame starts on the next accepted edge.
- P_DATA=8'hAA, PAR_EN=1, PAR_TYP=0, single DATA_VALID pulse -> TX_OUT sequence over 11 cycles, first to last, is 0,0,1,0,1,0,1,0,1,0,1 (start, data LSB first, parity 0, stop). Packed with the start bit at index 0 this is 11'b10101010100. BUSY=1 for exactly those 11 cycles.
- P_DATA=8'hAA, PAR_EN=1, PAR_TYP=1 -> identical frame except parity bit=1.
- P_DATA=8'h01, PAR_EN=0 -> 10-cycle frame 0,1,0,0,0,0,0,0,0,1. BUSY=1 for 10 cycles.
- DATA_VALID held high and P_DATA changed mid-frame -> current frame is unaffected. One idle cycle follows, then the next frame carries the P_DATA value present at its acceptance edge.
- Assert RST during data bit 4 -> next edge gives TX_OUT=1, BUSY=0, state IDLE. The next DATA_VALID starts a full fresh frame.

Source files
------------

// File: rtl/top_uart_if.sv
// Byte-in / serial-out bundle for top_uart, plus a read-only view of the FSM state.
// The master drives the byte side and the slave (top_uart) drives the line side.
interface top_uart_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;
  logic [2:0]            state_dbg;

  // Handshake: DATA_VALID is a one-cycle request with no ready. It is taken on a
  // rising edge only while the FSM is IDLE (BUSY low); otherwise it is dropped.
  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, BUSY, state_dbg
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, BUSY, state_dbg
  );
endinterface

// File: rtl/top_uart.sv
// UART transmitter, one bit per CLK: start, data LSB first, optional parity, stop.
// Parity support is compiled in only when UART_PARITY_EN is defined.
module top_uart #(
  parameter int DATA_WIDTH = 8
) (
  input logic      CLK,
  input logic      RST,
  top_uart_if.slave u
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_go;

`ifdef UART_PARITY_EN
  logic par_en_q, par_typ_q;
  logic par_bit;

  assign par_bit = (^data_q) ^ par_typ_q;
  assign par_go  = par_en_q;
`else
  wire unused_par = u.PAR_EN ^ u.PAR_TYP;

  assign par_go = 1'b0;
`endif

  // State register; TX_OUT and BUSY are registered alongside it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Frame settings are captured only at the accepting edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= '0;
`ifdef UART_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else if (state_q == IDLE && u.DATA_VALID) begin
      data_q <= u.P_DATA;
`ifdef UART_PARITY_EN
      par_en_q  <= u.PAR_EN;
      par_typ_q <= u.PAR_TYP;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (u.DATA_VALID) state_d = START;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = par_go ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values are decoded from the next state so they land with it.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      IDLE:  busy_d = 1'b0;
      START: tx_d   = 1'b0;
      DATA:  tx_d   = data_q[cnt_d];
`ifdef UART_PARITY_EN
      PARITY: tx_d  = par_bit;
`endif
      STOP:  tx_d   = 1'b1;
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign u.TX_OUT    = tx_q;
  assign u.BUSY      = busy_q;
  assign u.state_dbg = state_q;

endmodule

// File: tb/tb_top_uart.sv
// Directed bench for top_uart; expected frames are hand-packed with the start bit at index 0.
// Frame lengths and parity bits follow whether UART_PARITY_EN is defined.
module tb_top_uart;

  logic CLK_tb;
  logic RST;
  int   errors;
  int   checks;

  top_uart_if #(.DATA_WIDTH(8)) u_if ();

  top_uart #(.DATA_WIDTH(8)) dut (
    .CLK (CLK_tb),
    .RST (RST),
    .u   (u_if.slave)
  );

  initial CLK_tb = 1'b0;
  always #5 CLK_tb = ~CLK_tb;

  task automatic tick();
    @(posedge CLK_tb);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, {7'd0, u_if.TX_OUT}, 8'd1);
    chk({tag, "_busy"}, {7'd0, u_if.BUSY}, 8'd0);
  endtask

  // Called just after the accepting edge; walks the frame, then the following idle cycle.
  task automatic check_frame(input string tag, input logic [11:0] f, input int len);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), {7'd0, u_if.TX_OUT}, {7'd0, f[i]});
      chk($sformatf("%s_busy%0d", tag, i), {7'd0, u_if.BUSY}, 8'd1);
      tick();
    end
    chk_idle({tag, "_end"});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RST = 1'b1;
    u_if.P_DATA     = 8'hAA;
    u_if.DATA_VALID = 1'b1;
    u_if.PAR_EN     = 1'b1;
    u_if.PAR_TYP    = 1'b0;

    // Reset held for two edges with DATA_VALID high
    tick();
    chk_idle("rst0");
    chk("rst0_state", {5'd0, u_if.state_dbg}, 8'd0);
    tick();
    chk_idle("rst1");
    chk("rst1_state", {5'd0, u_if.state_dbg}, 8'd0);

    // First accepted edge after release: 0xAA even parity
    RST = 1'b0;
    tick();
    u_if.DATA_VALID = 1'b0;
    chk("aa_even_state", {5'd0, u_if.state_dbg}, 8'd1);
`ifdef UART_PARITY_EN
    check_frame("aa_even", 12'b0101_0101_0100, 11);
`else
    check_frame("aa_even", 12'b0011_0101_0100, 10);
`endif
    tick();
    chk_idle("quiet0");

    // 0xAA odd parity
    u_if.PAR_TYP    = 1'b1;
    u_if.DATA_VALID = 1'b1;
    tick();
    u_if.DATA_VALID = 1'b0;
`ifdef UART_PARITY_EN
    check_frame("aa_odd", 12'b0111_0101_0100, 11);
`else
    check_frame("aa_odd", 12'b0011_0101_0100, 10);
`endif

    // 0x01 without parity
    u_if.P_DATA     = 8'h01;
    u_if.PAR_EN     = 1'b0;
    u_if.PAR_TYP    = 1'b0;
    u_if.DATA_VALID = 1'b1;
    tick();
    u_if.DATA_VALID = 1'b0;
    check_frame("x01", 12'b0010_0000_0010, 10);

    // DATA_VALID held, inputs changed mid-frame
    u_if.P_DATA     = 8'h3C;
    u_if.PAR_EN     = 1'b1;
    u_if.PAR_TYP    = 1'b0;
    u_if.DATA_VALID = 1'b1;
    tick();
    u_if.P_DATA  = 8'hC5;
    u_if.PAR_EN  = 1'b0;
    u_if.PAR_TYP = 1'b1;
`ifdef UART_PARITY_EN
    check_frame("hold_3c", 12'b0100_0111_1000, 11);
`else
    check_frame("hold_3c", 12'b0010_0111_1000, 10);
`endif
    tick();
    u_if.P_DATA = 8'hFF;
    check_frame("hold_c5", 12'b0011_1000_1010, 10);
    u_if.DATA_VALID = 1'b0;
    tick();
    chk_idle("hold_after");

    // Reset during data bit 4 of 0x0F
    u_if.P_DATA     = 8'h0F;
    u_if.PAR_EN     = 1'b0;
    u_if.DATA_VALID = 1'b1;
    tick();
    u_if.DATA_VALID = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mid_tx%0d", i), {7'd0, u_if.TX_OUT},
          {7'd0, (i >= 1 && i <= 4) ? 1'b1 : 1'b0});
      chk($sformatf("mid_busy%0d", i), {7'd0, u_if.BUSY}, 8'd1);
      if (i < 5) tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_idle("mid_rst");
    chk("mid_rst_state", {5'd0, u_if.state_dbg}, 8'd0);
    tick();
    chk_idle("mid_rst_quiet");

    // Fresh frame after the mid-frame reset: 0x5A odd parity
    u_if.P_DATA     = 8'h5A;
    u_if.PAR_EN     = 1'b1;
    u_if.PAR_TYP    = 1'b1;
    u_if.DATA_VALID = 1'b1;
    tick();
    u_if.DATA_VALID = 1'b0;
`ifdef UART_PARITY_EN
    check_frame("fresh_5a", 12'b0110_1011_0100, 11);
`else
    check_frame("fresh_5a", 12'b0010_1011_0100, 10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
